// File: rtl/cic_decim.sv
// Three-stage CIC decimator: 14-bit signed input, decimation by R, 16-bit signed output with a 5-cycle latency.
// Define CIC_ROUND_EN for round-half-up output scaling with saturation; the default build truncates.
module cic_decim #(
  parameter int R = 8,
  parameter int N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] in_data,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam int LR  = $clog2(R);
  localparam int W   = 14 + 3 * LR;
  // One capture stage, N comb stages and one scaling stage lead to the output register.
  localparam int LAT = N + 2;

  logic signed [W-1:0] in_ext;
  logic signed [W-1:0] integ1, integ2, integ3;
  logic signed [W-1:0] integ1_nxt, integ2_nxt, integ3_nxt;
  logic signed [W-1:0] cap;
  logic signed [W-1:0] comb1, comb2, comb3;
  logic signed [W-1:0] dly1, dly2, dly3;
  logic [LR-1:0]       cnt;
  logic [LAT-1:0]      vld;
  logic [15:0]         scaled;
  logic [15:0]         scale_nxt;
  logic                dec_event;

  assign in_ext    = {{(W - 14){in_data[13]}}, in_data};
  assign dec_event = in_valid && (cnt == LR'(R - 1));

  // The integrators chain combinationally so each one sees the current sample; the captured value includes it.
  assign integ1_nxt = integ1 + in_ext;
  assign integ2_nxt = integ2 + integ1_nxt;
  assign integ3_nxt = integ3 + integ2_nxt;

`ifdef CIC_ROUND_EN
  localparam logic signed [W:0] HALF = (W + 1)'(1) << (W - 17);

  logic signed [W:0]  rnd_sum;
  logic signed [16:0] rnd_q;
  logic               unused_rnd_lsbs;

  assign rnd_sum         = {comb3[W-1], comb3} + HALF;
  assign rnd_q           = rnd_sum[W:W-16];
  assign unused_rnd_lsbs = ^rnd_sum[W-17:0];

  // NOTE: always_comb assigns a default first so no path can leave scale_nxt unassigned and infer a latch.
  always_comb begin
    scale_nxt = rnd_q[15:0];
    if (rnd_q[16] != rnd_q[15]) scale_nxt = rnd_q[16] ? 16'h8000 : 16'h7fff;
  end
`else
  logic unused_trunc_lsbs;

  assign scale_nxt         = comb3[W-1:W-16];
  assign unused_trunc_lsbs = ^comb3[W-17:0];
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values, which keeps the pipeline ordering exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      integ1    <= '0;
      integ2    <= '0;
      integ3    <= '0;
      cnt       <= '0;
      vld       <= '0;
      cap       <= '0;
      comb1     <= '0;
      comb2     <= '0;
      comb3     <= '0;
      dly1      <= '0;
      dly2      <= '0;
      dly3      <= '0;
      scaled    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        integ1 <= integ1_nxt;
        integ2 <= integ2_nxt;
        integ3 <= integ3_nxt;
        cnt    <= cnt + 1'b1;
      end

      vld <= {vld[LAT-2:0], dec_event};
      if (dec_event) cap <= integ3_nxt;

      // The comb delay registers advance only with decimated samples, never with raw input cycles.
      if (vld[0]) begin
        comb1 <= cap - dly1;
        dly1  <= cap;
      end
      if (vld[1]) begin
        comb2 <= comb1 - dly2;
        dly2  <= comb1;
      end
      if (vld[2]) begin
        comb3 <= comb2 - dly3;
        dly3  <= comb2;
      end
      if (vld[3]) scaled <= scale_nxt;

      if (vld[LAT-1]) begin
        out_data  <= scaled;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// Directed testbench for cic_decim (R=8): DC table, latency, in_valid gaps, backpressure, mid-run reset, impulse.
// Expected values are hand-derived; CIC_ROUND_EN switches the few values that differ under rounding.
module tb_cic_decim;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int got [16];
  int got_n;

  typedef struct {
    int din;
    int exp0;
    int exp1;
    int exp_dc;
  } dc_vec_t;

  dc_vec_t vecs [7];

  cic_decim #(.R(8), .N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst      = 1'b0;
  endtask

  // Streams a constant (or an impulse followed by zeros) and records each output word.
  task automatic run_dc(input int v, input int n_out, input bit gaps, input bit impulse);
    int budget = 0;
    int idle   = 0;
    got_n   = 0;
    in_data = 14'(v);
    while (got_n < n_out && budget < 2000) begin
      if (gaps && idle > 0) begin
        in_valid = 1'b0;
        idle--;
      end else begin
        in_valid = 1'b1;
        if (gaps) idle = int'($urandom_range(0, 2));
      end
      step();
      if (impulse && in_valid) in_data = 14'd0;
      if (out_valid) begin
        got[got_n] = int'($signed(out_data));
        got_n++;
      end
      budget++;
    end
    in_valid = 1'b0;
    if (got_n < n_out) check("output_timeout", got_n, n_out);
  endtask

  initial begin
    int seen;
    int first_valid;

    // Outputs for DC input v from reset: floor(v*120/128), floor(v*456/128), then 4*v.
`ifdef CIC_ROUND_EN
    vecs[0] = '{din: 1000,  exp0: 938,   exp1: 3563,   exp_dc: 4000};
    vecs[1] = '{din: -8192, exp0: -7680, exp1: -29184, exp_dc: -32768};
    vecs[2] = '{din: 1,     exp0: 1,     exp1: 4,      exp_dc: 4};
    vecs[3] = '{din: -1,    exp0: -1,    exp1: -4,     exp_dc: -4};
    vecs[4] = '{din: 8191,  exp0: 7679,  exp1: 29180,  exp_dc: 32764};
    vecs[5] = '{din: 0,     exp0: 0,     exp1: 0,      exp_dc: 0};
    vecs[6] = '{din: -1000, exp0: -937,  exp1: -3562,  exp_dc: -4000};
`else
    vecs[0] = '{din: 1000,  exp0: 937,   exp1: 3562,   exp_dc: 4000};
    vecs[1] = '{din: -8192, exp0: -7680, exp1: -29184, exp_dc: -32768};
    vecs[2] = '{din: 1,     exp0: 0,     exp1: 3,      exp_dc: 4};
    vecs[3] = '{din: -1,    exp0: -1,    exp1: -4,     exp_dc: -4};
    vecs[4] = '{din: 8191,  exp0: 7679,  exp1: 29180,  exp_dc: 32764};
    vecs[5] = '{din: 0,     exp0: 0,     exp1: 0,      exp_dc: 0};
    vecs[6] = '{din: -1000, exp0: -938,  exp1: -3563,  exp_dc: -4000};
`endif

    rst       = 1'b1;
    in_data   = 14'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    // Latency: 8 samples of 100, out_valid exactly 5 edges after the 8th sample edge.
    in_data  = 14'd100;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    in_valid    = 1'b0;
    first_valid = 0;
    for (int k = 1; k <= 8 && first_valid == 0; k++) begin
      step();
      if (out_valid) first_valid = k;
    end
    check("latency_edges", first_valid, 5);
`ifdef CIC_ROUND_EN
    check("latency_value", int'($signed(out_data)), 94);
`else
    check("latency_value", int'($signed(out_data)), 93);
`endif

    for (int t = 0; t < 7; t++) begin
      do_reset();
      run_dc(vecs[t].din, 5, 1'b0, 1'b0);
      check($sformatf("dc%0d_out0", vecs[t].din), got[0], vecs[t].exp0);
      check($sformatf("dc%0d_out1", vecs[t].din), got[1], vecs[t].exp1);
      for (int j = 2; j < 5; j++)
        check($sformatf("dc%0d_out%0d", vecs[t].din, j), got[j], vecs[t].exp_dc);
    end

    // in_valid gaps must give the same output sequence as continuous DC 1000.
    do_reset();
    run_dc(1000, 6, 1'b1, 1'b0);
    check("gaps_out0", got[0], vecs[0].exp0);
    check("gaps_out1", got[1], vecs[0].exp1);
    for (int j = 2; j < 6; j++) check($sformatf("gaps_out%0d", j), got[j], 4000);

    // Backpressure across two decimation events.
    do_reset();
    out_ready = 1'b0;
    in_data   = 14'd1000;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_out_data", int'($signed(out_data)), vecs[0].exp1);
    check("bp_overrun", int'(overrun), 1);
    step();
    check("bp_hold_data", int'($signed(out_data)), vecs[0].exp1);
    out_ready = 1'b1;
    step();
    check("bp_drain_valid", int'(out_valid), 0);
    check("bp_drain_overrun", int'(overrun), 1);
    do_reset();
    check("bp_reset_overrun", int'(overrun), 0);

    // Reset one edge after a decimation event discards it.
    in_data  = 14'd1000;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) step();
    do_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    run_dc(1000, 3, 1'b0, 1'b0);
    check("midrst_out0", got[0], vecs[0].exp0);
    check("midrst_out1", got[1], vecs[0].exp1);
    check("midrst_out2", got[2], 4000);

    // Impulse of 1000: comb3 = 36000, 28000, 0, 0 before scaling by 1/128.
    do_reset();
    run_dc(1000, 4, 1'b0, 1'b1);
    check("imp_out0", got[0], 281);
`ifdef CIC_ROUND_EN
    check("imp_out1", got[1], 219);
`else
    check("imp_out1", got[1], 218);
`endif
    check("imp_out2", got[2], 0);
    check("imp_out3", got[3], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cic_decim.md
CIC_DECIM -- requirements
Module: cic_decim

Interface
REQ-001 SHALL have parameter R, default 8, decimation ratio; a power of two, 2..64.
REQ-002 SHALL have parameter N, default 3, number of integrator and comb stages; fixed at 3.
REQ-003 SHALL have internal width W = 14 + 3*log2(R), derived and not overridable.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  14  signed sample from the DAC/DDS stage (db_cos).
REQ-007 in_valid  input  1  in_data qualifier; the stage SHALL sample in_data on every clk edge where in_valid=1, with no backpressure.
REQ-008 out_data  output  16  signed decimated sample.
REQ-009 out_valid  output  1  out_data qualifier.
REQ-010 out_ready  input  1  downstream accept; a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-011 overrun  output  1  sticky flag: a decimated sample was lost.

Function
REQ-012 SHALL run 3 cascaded W-bit two's-complement integrators; each SHALL update only on in_valid edges, and wrap-around SHALL be modular with no saturation.
REQ-013 SHALL sign-extend in_data to W bits before integrator 1.
REQ-014 SHALL run a sample counter 0..R-1 that increments per accepted input and wraps from R-1 to 0.
REQ-015 On the edge accepting an input while the counter = R-1, the last integrator output SHALL be captured into the comb pipeline (decimation event).
REQ-016 SHALL run 3 comb stages, y = x - x_prev with differential delay 1; each stage SHALL be registered and advance one stage per clk after the decimation event, independent of in_valid.
REQ-017 Output scaling SHALL be out_data = comb3[W-1 : W-16], truncating toward minus infinity; DC gain is exactly 4 for any R.
REQ-018 out_valid SHALL rise on the 5th clk edge after the edge that accepted the R-th sample, a fixed latency of 5 cycles.
REQ-019 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL clear on a transfer edge unless a new sample loads on that same edge; in that case the new sample SHALL load and out_valid SHALL stay 1.
REQ-021 If a new sample arrives while out_valid=1 and out_ready=0, the new sample SHALL overwrite out_data, out_valid SHALL remain 1, and overrun SHALL set.
REQ-022 overrun SHALL clear only on rst.
REQ-023 in_valid gaps of any length SHALL NOT alter results; output depends only on the sequence of accepted samples.

Reset
REQ-024 On rst=1 at an edge, the block SHALL clear all integrators, combs, comb delay registers and the sample counter, and set out_data=0, out_valid=0 and overrun=0.
REQ-025 rst SHALL take priority over in_valid and out_ready on the same edge, and SHALL discard any decimation event in flight.
REQ-026 The first input accepted after rst SHALL be counted as sample 0.

Configuration
REQ-027 Macro CIC_ROUND_EN SHALL select the output scaling rule.
REQ-028 With CIC_ROUND_EN defined: out_data SHALL equal (comb3 + 2^(W-17)) >> (W-16), round half up, saturated to [-32768, 32767]; latency SHALL be unchanged at 5.
REQ-029 Without CIC_ROUND_EN: out_data SHALL be plain truncation per REQ-017, with no rounding or saturation logic present.

Verification
REQ-030 DC: R=8, in_data=1000 continuous with in_valid=1 and out_ready=1; after settling (3 outputs) every out_data SHALL be 4000, and out_data SHALL be -32768 for input -8192.
REQ-031 Latency: after rst, apply 8 valid samples of 100; out_valid SHALL rise exactly 5 edges after the 8th sample edge.
REQ-032 Gaps: DC 1000 with in_valid toggling 1-0-0 pseudo-randomly; the output sequence SHALL be identical to the REQ-030 output sequence.
REQ-033 Backpressure: hold out_ready=0 across two decimation events; out_data SHALL show the second sample, overrun SHALL be 1, out_valid SHALL be 1; then out_ready=1 for one edge SHALL give out_valid=0 with overrun still 1.
REQ-034 Reset mid-operation: assert rst one edge after a decimation event; out_valid SHALL never assert for that event, and a subsequent DC 1000 SHALL reproduce the REQ-030 sequence.
REQ-035 Macro: with CIC_ROUND_EN, R=8 and DC input 1 SHALL settle to out_data=4, and DC input 8191 SHALL settle to 32764; without the macro, impulse 1000 then zeros SHALL match a bit-true CIC model using truncation.
